// File: rtl/universal_reg.sv
// universal_reg: WIDTH-bit edge-triggered register with eight operating modes
// (hold, load, shift left/right, rotate left/right, count up/down), an enable,
// true/complemented outputs and single-cycle sout/co status pulses.
module universal_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qp,
    output logic             sout,
    output logic             co,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_UP   = 3'b110,
        MODE_DOWN = 3'b111
    } mode_e;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             co_q, co_d;

    // Extra top bit carries the wrap-around flag for both count directions:
    // overflow on increment, borrow on decrement.
    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] dec_sum;

    assign inc_sum = {1'b0, q_q} + ONE;
    assign dec_sum = {1'b0, q_q} - ONE;

    // Next-state selection; sout/co default to 0 so they pulse for one cycle only.
    always_comb begin
        q_d    = q_q;
        sout_d = 1'b0;
        co_d   = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = D;
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sin_l};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = {sin_r, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_UP: begin
                    q_d  = inc_sum[WIDTH-1:0];
                    co_d = inc_sum[WIDTH];
                end
                MODE_DOWN: begin
                    q_d  = dec_sum[WIDTH-1:0];
                    co_d = dec_sum[WIDTH];
                end
                default: q_d = q_q;
            endcase
        end
    end

    // State register with asynchronous reset to RST_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RST_VAL;
            sout_q <= 1'b0;
            co_q   <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            co_q   <= co_d;
        end
    end

    // Complement and zero flag come straight from Q so they never lag it.
    assign Q    = q_q;
    assign Qp   = ~q_q;
    assign zero = (q_q == '0);
    assign sout = sout_q;
    assign co   = co_q;

endmodule

// File: tb/tb_universal_reg.sv
// Self-checking bench for universal_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_universal_reg;

    localparam int         W   = 8;
    localparam logic [7:0] RSV = 8'hA5;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] D;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] Q;
    logic [7:0] Qp;
    logic       sout;
    logic       co;
    logic       zero;

    universal_reg #(.WIDTH(W), .RST_VAL(RSV)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .D     (D),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .Q     (Q),
        .Qp    (Qp),
        .sout  (sout),
        .co    (co),
        .zero  (zero)
    );

    // Clock can be held still to show that reset needs no edge.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: plain integers, arithmetic on 0..255.
    int mq, ms, mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string name, input int eq, input int es, input int ec);
        chk({name, ".Q"},    32'(Q),    32'(eq));
        chk({name, ".Qp"},   32'(Qp),   32'(255 - eq));
        chk({name, ".zero"}, 32'(zero), 32'(eq == 0));
        chk({name, ".sout"}, 32'(sout), 32'(es));
        chk({name, ".co"},   32'(co),   32'(ec));
    endtask

    // Behavioural model of one clock edge.
    task automatic model(input int e, input int m, input int d, input int sl, input int sr);
        int q;
        q  = mq;
        ms = 0;
        mc = 0;
        if (e != 0) begin
            case (m)
                1: mq = d;
                2: begin mq = (q * 2 + sl) % 256;       ms = q / 128; end
                3: begin mq = q / 2 + sr * 128;         ms = q % 2;   end
                4: begin mq = (q * 2) % 256 + q / 128;  ms = q / 128; end
                5: begin mq = q / 2 + (q % 2) * 128;    ms = q % 2;   end
                6: begin mq = (q + 1) % 256;            mc = (q == 255); end
                7: begin mq = (q + 255) % 256;          mc = (q == 0);   end
                default: mq = q;
            endcase
        end
    endtask

    // Drive inputs, advance one edge, update model, sample 1 time unit later.
    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] d,
                        input logic sl, input logic sr);
        en = e; mode = m; D = d; sin_l = sl; sin_r = sr;
        model(int'(e), int'(m), int'(d), int'(sl), int'(sr));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [7:0] q;
        logic       so;
        logic       c;
    } vec_t;

    vec_t vt[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 3'b001, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[10] = '{1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0};
        vt[11] = '{1'b0, 3'b010, 8'h00, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0};
        vt[12] = '{1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[13] = '{1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[14] = '{1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};
        vt[15] = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};

        // Reset with the clock stopped.
        clk_run = 1'b0;
        rst = 1'b1; en = 1'b0; mode = 3'b000; D = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        #3;
        check_outs("reset_noclk", 32'hA5, 0, 0);
        mq = 32'hA5; ms = 0; mc = 0;
        clk_run = 1'b1;
        #13;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b001, 8'h3C, 1'b1, 1'b1);
            check_outs("en0_hold", 32'hA5, 0, 0);
        end

        // Table-driven sequence with hand-derived expectations.
        for (int i = 0; i < 16; i++) begin
            step(vt[i].en, vt[i].mode, vt[i].d, vt[i].sl, vt[i].sr);
            check_outs($sformatf("vec%0d", i), int'(vt[i].q), int'(vt[i].so), int'(vt[i].c));
        end

        // Load versus latch: D wiggles between edges, only the edge value counts.
        step(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
        check_outs("load00", 0, 0, 0);
        D = 8'hFF;
        #2;
        check_outs("load_mid_ff", 0, 0, 0);
        D = 8'h00;
        #1;
        check_outs("load_mid_00", 0, 0, 0);
        step(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
        check_outs("loadFF", 255, 0, 0);
        D = 8'h00;
        #3;
        check_outs("loadFF_mid", 255, 0, 0);

        // Rotate left eight times from 81: sout high on edges 1 and 8 only.
        step(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
            chk($sformatf("rol_sout%0d", i + 1), 32'(sout), 32'((i == 0) || (i == 7)));
            chk($sformatf("rol_q%0d", i + 1), 32'(Q), 32'(mq));
        end
        chk("rol_final", 32'(Q), 32'h81);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
            chk($sformatf("ror_sout%0d", i + 1), 32'(sout), 32'((i == 0) || (i == 7)));
            chk($sformatf("ror_q%0d", i + 1), 32'(Q), 32'(mq));
        end
        chk("ror_final", 32'(Q), 32'h81);

        // Async reset in the middle of a count.
        step(1'b1, 3'b001, 8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        check_outs("count13", 32'h13, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("midcount_rst", 32'hA5, 0, 0);
        mq = 32'hA5; ms = 0; mc = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        step(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        check_outs("resume", 32'hA6, 0, 0);

        // Randomised operations against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom), 1'($urandom));
            check_outs($sformatf("rnd%0d", i), mq, ms, mc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
